// File: rtl/shift_add_mult8_if.sv
// Request/result bundle for the shift-add multiplier.
// The requester drives start/A/B; the multiplier drives busy/done/Product.
interface shift_add_mult8_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] Product;

  modport master (
    output start, A, B,
    input  busy, done, Product
  );

  modport slave (
    input  start, A, B,
    output busy, done, Product
  );
endinterface

// File: rtl/shift_add_mult8.sv
// Sequential NxN unsigned shift-add multiplier.
// One multiplier bit per cycle through an N-bit ripple adder.
module shift_add_mult8 #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  shift_add_mult8_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   acc_hi_q, acc_hi_d;
  logic [N-1:0]   acc_lo_q, acc_lo_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0] add_b;
  logic [N-1:0] sum;
  logic [N:0]   carry;
  logic         cout;
  logic         last;

  assign last = (count_q == CW'(N - 1));

  // Ripple adder, Cin tied low.
  always_comb begin
    add_b    = acc_lo_q[0] ? mcand_q : '0;
    carry    = '0;
    sum      = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]     = acc_hi_q[i] ^ add_b[i] ^ carry[i];
      carry[i+1] = (acc_hi_q[i] & add_b[i]) |
                   (carry[i] & (acc_hi_q[i] ^ add_b[i]));
    end
    cout = carry[N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.A;
          acc_hi_d = '0;
          acc_lo_d = bus.B;
          count_d  = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        // Cout becomes the new MSB of the partial product.
        acc_hi_d = {cout, sum[N-1:1]};
        acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
        count_d  = count_q + CW'(1);
        if (last) begin
          prod_d = {cout, sum, acc_lo_q[N-1:1]};
          done_d = 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Product = prod_q;
endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed and random checks of shift_add_mult8 against a*b.
// Timing, hold-off of start, async reset and back-to-back operation.
module tb_shift_add_mult8;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   last_prod = 0;

  shift_add_mult8_if #(.N(8)) bus ();

  shift_add_mult8 #(.N(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns edges after acceptance until done seen; checks Product stability.
  task automatic wait_done(output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.Product !== 16'(last_prod)) stable = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a,
                    input logic [7:0] b);
    int  n;
    bit  st;
    int  e;
    e = int'(a) * int'(b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 8'($urandom);
    bus.B = 8'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(n, st);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_hold"}, 32'(st), 32'd1);
    chk({tag, "_prod"}, 32'(bus.Product), 32'(e));
    last_prod = e;
    @(posedge clk);
    #1;
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done0"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int  n;
    bit  st;
    int  seen;
    int  gap;
    int  low;

    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_prod", 32'(bus.Product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    op("d13x11", 8'd13, 8'd11);
    chk("d13x11_val", 32'(bus.Product), 32'h008F);
    op("d255x255", 8'd255, 8'd255);
    chk("d255_val", 32'(bus.Product), 32'hFE01);
    op("d0x200", 8'd0, 8'd200);
    op("d200x0", 8'd200, 8'd0);
    op("d1x255", 8'd1, 8'd255);
    op("d128x2", 8'd128, 8'd2);

    // start held high; operands change mid-run
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd3;
    bus.B = 8'd5;
    @(posedge clk);
    #1;
    chk("hold_busy", 32'(bus.busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.A = 8'd7;
    bus.B = 8'd9;
    wait_done(n, st);
    chk("hold_lat", 32'(n + 3), 32'd8);
    chk("hold_prod1", 32'(bus.Product), 32'd15);
    last_prod = 15;
    @(posedge clk);
    #1;
    chk("hold_idle_busy", 32'(bus.busy), 32'd0);
    chk("hold_idle_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("hold_reacc", 32'(bus.busy), 32'd1);
    wait_done(n, st);
    chk("hold_lat2", 32'(n), 32'd8);
    chk("hold_prod2", 32'(bus.Product), 32'd63);
    last_prod = 63;
    @(posedge clk);
    #1;

    // async reset after 4 iterations
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd100;
    bus.B = 8'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_prod", 32'(bus.Product), 32'd0);
    last_prod = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("arst_nodone", 32'(seen), 32'd0);
    op("d2x3", 8'd2, 8'd3);

    for (int i = 0; i < 16; i++) begin
      op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom));
    end

    // back-to-back with start held
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 8'd1;
    bus.B = 8'd1;
    gap = 0;
    while (bus.done !== 1'b1 && gap < 30) begin
      @(posedge clk);
      #1;
      gap++;
    end
    chk("b2b_first", 32'(bus.done), 32'd1);
    chk("b2b_prod0", 32'(bus.Product), 32'd1);
    for (int r = 0; r < 3; r++) begin
      gap = 0;
      low = 0;
      do begin
        @(posedge clk);
        #1;
        gap++;
        if (bus.busy === 1'b0) low++;
      end while (bus.done !== 1'b1 && gap < 30);
      chk($sformatf("b2b_gap%0d", r), 32'(gap), 32'd10);
      chk($sformatf("b2b_low%0d", r), 32'(low), 32'd1);
      chk($sformatf("b2b_prod%0d", r), 32'(bus.Product), 32'd1);
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
